hard_mem_1rw_rmw_adapter: RTL

- Request-side adapter placed directly upstream of the 1024x46 single-port hard-memory wrapper.
- Converts a valid/ready request stream with per-bit write mask into the wrapper's active-low chip-select/write-enable port protocol.
- Partial writes become read-modify-write sequences. Read data is buffered in a 2-entry output queue with valid/yumi back-pressure.
- Every memory access goes through this block; the core never drives the wrapper directly.

---
 rtl/hard_mem_1rw_rmw_adapter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hard_mem_1rw_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : hard_mem_1rw_rmw_adapter
// Description : Request adapter in front of the 1024x46 single-port hard
//               memory wrapper. Turns a valid/ready request stream with a
//               per-bit write mask into active-low csb/web port cycles.
//               Partial writes become read-modify-write pairs, and read data
//               is returned through a 2-entry valid/yumi output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module hard_mem_1rw_rmw_adapter #(
    parameter int DATA_WIDTH = 46,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_ELS    = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    // request side
    input  logic                  v_i,
    input  logic                  w_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] w_mask_i,
    output logic                  ready_o,

    // read response side
    output logic                  v_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  yumi_i,

    // hard memory wrapper port
    output logic                  mem_csb_o,
    output logic                  mem_web_o,
    output logic                  mem_wmask_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    // Queue occupancy counter must hold 0..OUT_ELS, plus one spare code so
    // count + in-flight read never overflows.
    localparam int CNT_W = 2;
    // Queue depth is fixed at two entries, so a single wrapping pointer bit.
    localparam int PTR_W = 1;
    localparam logic [CNT_W-1:0] C_OUT_ELS = CNT_W'(OUT_ELS);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_MERGE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    rd_inflight_q, rd_inflight_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;

    logic [DATA_WIDTH-1:0]   q_mem_q [OUT_ELS];
    logic [DATA_WIDTH-1:0]   q_mem_d [OUT_ELS];
    logic [PTR_W-1:0]        q_wr_ptr_q, q_wr_ptr_d;
    logic [PTR_W-1:0]        q_rd_ptr_q, q_rd_ptr_d;
    logic [CNT_W-1:0]        q_count_q, q_count_d;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_rd_issue;
    logic                    w_mask_full;
    logic [CNT_W-1:0]        w_occupancy;
    logic [DATA_WIDTH-1:0]   w_merged;

    // The wrapper's mask pin is unused; masking is done by read-modify-write.
    assign mem_wmask_o = 1'b1;

    // Queue handshake and slot accounting.
    // A pop in the current cycle frees a slot, so the consumer popping every
    // cycle lets reads stream at one per cycle.
    always_comb begin
        w_push      = rd_inflight_q;
        w_pop       = yumi_i && (q_count_q != '0);
        w_occupancy = q_count_q + {{(CNT_W-1){1'b0}}, rd_inflight_q}
                      - {{(CNT_W-1){1'b0}}, w_pop};
        w_mask_full = &w_mask_i;
        w_merged    = (data_q & mask_q) | (mem_data_i & ~mask_q);
    end

    // Request FSM: next state, request latching and the memory port drive.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        w_rd_issue = 1'b0;
        ready_o    = 1'b0;
        mem_csb_o  = 1'b1;
        mem_web_o  = 1'b1;
        mem_addr_o = addr_i;
        mem_data_o = data_i;

        case (state_q)
            ST_IDLE: begin
                ready_o = !reset_i && (w_occupancy < C_OUT_ELS);
                if (v_i && ready_o) begin
                    mem_csb_o = 1'b0;
                    if (!w_i) begin
                        w_rd_issue = 1'b1;
                    end else if (w_mask_full) begin
                        mem_web_o = 1'b0;
                    end else begin
                        // Partial write: fetch the old word now, merge next cycle.
                        addr_d  = addr_i;
                        data_d  = data_i;
                        mask_d  = w_mask_i;
                        state_d = ST_RMW_MERGE;
                    end
                end
            end
            ST_RMW_MERGE: begin
                mem_addr_o = addr_q;
                mem_data_o = w_merged;
                // A reset landing here drops the write so memory is untouched.
                if (!reset_i) begin
                    mem_csb_o = 1'b0;
                    mem_web_o = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_inflight_d = w_rd_issue;
    end

    // Output queue next-state: push returning read data, pop on yumi.
    always_comb begin
        for (int i = 0; i < OUT_ELS; i++) begin
            q_mem_d[i] = q_mem_q[i];
        end
        if (w_push) begin
            q_mem_d[q_wr_ptr_q] = mem_data_i;
        end
        q_wr_ptr_d = q_wr_ptr_q + PTR_W'(w_push);
        q_rd_ptr_d = q_rd_ptr_q + PTR_W'(w_pop);
        q_count_d  = q_count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            rd_inflight_q <= 1'b0;
            q_wr_ptr_q    <= '0;
            q_rd_ptr_q    <= '0;
            q_count_q     <= '0;
        end else begin
            state_q       <= state_d;
            rd_inflight_q <= rd_inflight_d;
            q_wr_ptr_q    <= q_wr_ptr_d;
            q_rd_ptr_q    <= q_rd_ptr_d;
            q_count_q     <= q_count_d;
        end
    end

    // Datapath registers; contents are only meaningful when qualified by state.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
        mask_q <= mask_d;
        for (int i = 0; i < OUT_ELS; i++) begin
            q_mem_q[i] <= q_mem_d[i];
        end
    end

    // Response outputs come straight from the queue head.
    always_comb begin
        v_o    = (q_count_q != '0);
        data_o = q_mem_q[q_rd_ptr_q];
    end

endmodule
`default_nettype wire
